// File: rtl/arbiter_grant_server.sv
// Grant consumer for the arbiter_iwrr handshake: accepts one-hot grants,
// services each for a fixed number of cycles, pulses a per-requester done,
// keeps saturating per-requester grant counters and flags multi-hot grants.
//
//   state | meaning
//   IDLE  | grant_ready high, waiting for a one-hot grant
//   SERVE | grant in service, down-counter running (held by svc_stall)
module arbiter_grant_server #(
  parameter int P_REQUESTER_NUM  = 4,
  parameter int P_SERVICE_CYCLES = 3,
  parameter int P_CNT_W          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [P_REQUESTER_NUM-1:0]           grant_valid,
  output logic                                 grant_ready,
  input  logic                                 svc_stall,
  output logic                                 svc_busy,
  output logic [$clog2(P_REQUESTER_NUM)-1:0]   svc_idx,
  output logic [P_REQUESTER_NUM-1:0]           svc_done,
  output logic [P_REQUESTER_NUM*P_CNT_W-1:0]   grant_cnt,
  input  logic                                 cnt_clr,
  output logic                                 onehot_err,
  input  logic                                 err_clr
);

  localparam int IDX_W = $clog2(P_REQUESTER_NUM);
  localparam int SVC_W = (P_SERVICE_CYCLES > 1) ? $clog2(P_SERVICE_CYCLES) : 1;
  localparam logic [SVC_W-1:0]   SVC_LOAD = SVC_W'(P_SERVICE_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state;
  logic [SVC_W-1:0] svc_cnt;
  logic             hot_any;
  logic             hot_multi;
  logic [IDX_W-1:0] hot_idx;
  logic             accept;
  logic             bad_grant;

  // Decode grant_valid: index of the set bit and whether more than one is set
  always_comb begin
    hot_any   = 1'b0;
    hot_multi = 1'b0;
    hot_idx   = '0;
    for (int i = 0; i < P_REQUESTER_NUM; i++) begin
      if (grant_valid[i]) begin
        if (hot_any) hot_multi = 1'b1;
        hot_any = 1'b1;
        hot_idx = IDX_W'(i);
      end
    end
  end

  // grant_ready is only ever high in IDLE, so it alone qualifies the handshake
  assign accept    = grant_ready & hot_any & ~hot_multi;
  assign bad_grant = grant_ready & hot_multi;

  // Service FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      svc_cnt     <= '0;
      grant_ready <= 1'b0;
      svc_busy    <= 1'b0;
      svc_idx     <= '0;
      svc_done    <= '0;
    end else begin
      svc_done <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SERVE;
            svc_idx     <= hot_idx;
            svc_cnt     <= SVC_LOAD;
            grant_ready <= 1'b0;
            svc_busy    <= 1'b1;
          end else begin
            grant_ready <= 1'b1;
          end
        end
        SERVE: begin
          if (!svc_stall) begin
            if (svc_cnt == '0) begin
              state       <= IDLE;
              svc_done    <= P_REQUESTER_NUM'(1) << svc_idx;
              grant_ready <= 1'b1;
              svc_busy    <= 1'b0;
            end else begin
              svc_cnt <= svc_cnt - 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_ready <= 1'b0;
          svc_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Per-requester saturating grant counters; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (cnt_clr) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
        if ((hot_idx == IDX_W'(i)) && (grant_cnt[i*P_CNT_W +: P_CNT_W] != CNT_MAX)) begin
          grant_cnt[i*P_CNT_W +: P_CNT_W] <= grant_cnt[i*P_CNT_W +: P_CNT_W] + 1'b1;
        end
      end
    end
  end

  // Sticky multi-hot flag; a new error outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (bad_grant) begin
      onehot_err <= 1'b1;
    end else if (err_clr) begin
      onehot_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbiter_grant_server.sv
// Bench for arbiter_grant_server: two instances (8-bit and 2-bit counters)
// share stimulus; expected outputs are queued per step and compared after the edge.
module tb_arbiter_grant_server;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [1:0] idx;
    logic [3:0] done;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] g;
    logic       s;
    logic       cc;
    logic       ec;
    exp_t       ex;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  gv;
  logic        stall, cclr, eclr;
  logic        ready, busy, err;
  logic [1:0]  idx;
  logic [3:0]  done;
  logic [31:0] gcnt;
  logic        ready2, busy2, err2;
  logic [1:0]  idx2;
  logic [3:0]  done2;
  logic [7:0]  gcnt2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  arbiter_grant_server #(.P_REQUESTER_NUM(4), .P_SERVICE_CYCLES(3), .P_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .grant_valid(gv), .grant_ready(ready),
    .svc_stall(stall), .svc_busy(busy), .svc_idx(idx), .svc_done(done),
    .grant_cnt(gcnt), .cnt_clr(cclr), .onehot_err(err), .err_clr(eclr));

  arbiter_grant_server #(.P_REQUESTER_NUM(4), .P_SERVICE_CYCLES(3), .P_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .grant_valid(gv), .grant_ready(ready2),
    .svc_stall(stall), .svc_busy(busy2), .svc_idx(idx2), .svc_done(done2),
    .grant_cnt(gcnt2), .cnt_clr(cclr), .onehot_err(err2), .err_clr(eclr));

  always #5 clk = ~clk;

  function automatic exp_t e(input logic r, input logic b, input logic [1:0] i,
                             input logic [3:0] d, input logic er);
    exp_t x;
    x.ready = r; x.busy = b; x.idx = i; x.done = d; x.err = er;
    return x;
  endfunction

  function automatic vec_t v(input logic [3:0] g, input logic s, input logic cc,
                             input logic ec, input exp_t ex);
    vec_t r;
    r.g = g; r.s = s; r.cc = cc; r.ec = ec; r.ex = ex;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(input logic [3:0] g, input logic s, input logic cc,
                      input logic ec, input exp_t ex, input string nm);
    exp_t x;
    gv = g; stall = s; cclr = cc; eclr = ec;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk(nm, {23'd0, ready, busy, idx, done, err}, {23'd0, x});
      chk({nm, "_w2"}, {23'd0, ready2, busy2, idx2, done2, err2}, {23'd0, x});
    end
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    step(t.g, t.s, t.cc, t.ec, t.ex, nm);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_outs"},  {23'd0, ready, busy, idx, done, err}, 32'd0);
    chk({nm, "_outs2"}, {23'd0, ready2, busy2, idx2, done2, err2}, 32'd0);
    chk({nm, "_cnt"},   gcnt, 32'd0);
    chk({nm, "_cnt2"},  {24'd0, gcnt2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[6];
    vec_t t2[5];

    // first grant to requester 0 right after reset release
    t1[0] = v(4'b0001, 0, 0, 0, e(1, 0, 2'd0, 4'b0000, 0));
    t1[1] = v(4'b0001, 0, 0, 0, e(0, 1, 2'd0, 4'b0000, 0));
    t1[2] = v(4'b0001, 0, 0, 0, e(0, 1, 2'd0, 4'b0000, 0));
    t1[3] = v(4'b0001, 0, 0, 0, e(0, 1, 2'd0, 4'b0000, 0));
    t1[4] = v(4'b0000, 0, 0, 0, e(1, 0, 2'd0, 4'b0001, 0));
    t1[5] = v(4'b0000, 0, 0, 0, e(1, 0, 2'd0, 4'b0000, 0));
    // multi-hot grants while idle (last served requester 3)
    t2[0] = v(4'b0110, 0, 0, 0, e(1, 0, 2'd3, 4'b0000, 1));
    t2[1] = v(4'b0000, 0, 0, 0, e(1, 0, 2'd3, 4'b0000, 1));
    t2[2] = v(4'b0000, 0, 0, 1, e(1, 0, 2'd3, 4'b0000, 0));
    t2[3] = v(4'b1100, 0, 0, 1, e(1, 0, 2'd3, 4'b0000, 1));
    t2[4] = v(4'b0000, 0, 0, 1, e(1, 0, 2'd3, 4'b0000, 0));

    rst_n = 1'b0; gv = 4'b0001; stall = 0; cclr = 0; eclr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(t1[i], $sformatf("first_grant_%0d", i));
    chk("cnt_req0", {24'd0, gcnt[7:0]}, 32'd1);

    // requester 2 held: accept every 4 cycles, including in the done cycle
    for (int s = 0; s < 5; s++) begin
      step(4'b0100, 0, 0, 0, e(0, 1, 2'd2, 4'b0000, 0), $sformatf("b2b_acc_%0d", s));
      step(4'b0100, 0, 0, 0, e(0, 1, 2'd2, 4'b0000, 0), $sformatf("b2b_s1_%0d", s));
      step(4'b0100, 0, 0, 0, e(0, 1, 2'd2, 4'b0000, 0), $sformatf("b2b_s2_%0d", s));
      step(4'b0100, 0, 0, 0, e(1, 0, 2'd2, 4'b0100, 0), $sformatf("b2b_done_%0d", s));
    end
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd2, 4'b0000, 0), "b2b_idle");
    chk("cnt_req2",      {24'd0, gcnt[23:16]}, 32'd5);
    chk("cnt_req2_sat2", {30'd0, gcnt2[5:4]},  32'd3);

    // stall for two cycles mid-service; multi-hot during service is ignored
    step(4'b1000, 0, 0, 0, e(0, 1, 2'd3, 4'b0000, 0), "stall_acc");
    step(4'b1111, 0, 0, 0, e(0, 1, 2'd3, 4'b0000, 0), "stall_mh_ignored");
    step(4'b0000, 1, 0, 0, e(0, 1, 2'd3, 4'b0000, 0), "stall_hold1");
    step(4'b0000, 1, 0, 0, e(0, 1, 2'd3, 4'b0000, 0), "stall_hold2");
    step(4'b0000, 0, 0, 0, e(0, 1, 2'd3, 4'b0000, 0), "stall_last");
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd3, 4'b1000, 0), "stall_done");
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd3, 4'b0000, 0), "stall_single_done");

    for (int i = 0; i < 5; i++) run_vec(t2[i], $sformatf("onehot_err_%0d", i));
    chk("cnt_after_err",  gcnt, 32'h0105_0001);
    chk("cnt2_after_err", {24'd0, gcnt2}, 32'h0000_0071);

    // counter clear, saturation of the 2-bit counters, clear on an accept edge
    step(4'b0000, 0, 1, 0, e(1, 0, 2'd3, 4'b0000, 0), "cnt_clr_idle");
    chk("cnt_cleared",  gcnt, 32'd0);
    chk("cnt2_cleared", {24'd0, gcnt2}, 32'd0);
    for (int s = 0; s < 5; s++) begin
      step(4'b0010, 0, 0, 0, e(0, 1, 2'd1, 4'b0000, 0), $sformatf("sat_acc_%0d", s));
      step(4'b0010, 0, 0, 0, e(0, 1, 2'd1, 4'b0000, 0), $sformatf("sat_s1_%0d", s));
      step(4'b0010, 0, 0, 0, e(0, 1, 2'd1, 4'b0000, 0), $sformatf("sat_s2_%0d", s));
      step(4'b0010, 0, 0, 0, e(1, 0, 2'd1, 4'b0010, 0), $sformatf("sat_done_%0d", s));
    end
    chk("cnt_req1_5",   gcnt, 32'h0000_0500);
    chk("cnt2_req1_sat", {24'd0, gcnt2}, 32'h0000_000C);
    step(4'b0010, 0, 1, 0, e(0, 1, 2'd1, 4'b0000, 0), "clr_on_accept");
    chk("clr_on_accept_cnt",  gcnt, 32'd0);
    chk("clr_on_accept_cnt2", {24'd0, gcnt2}, 32'd0);
    step(4'b0000, 0, 0, 0, e(0, 1, 2'd1, 4'b0000, 0), "clr_serve1");
    step(4'b0000, 0, 0, 0, e(0, 1, 2'd1, 4'b0000, 0), "clr_serve2");
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd1, 4'b0010, 0), "clr_served_done");
    chk("clr_cnt_stays0", gcnt, 32'd0);

    // async reset in the middle of a service
    step(4'b0001, 0, 0, 0, e(0, 1, 2'd0, 4'b0000, 0), "rst_acc");
    step(4'b0000, 0, 0, 0, e(0, 1, 2'd0, 4'b0000, 0), "rst_serve");
    #2 rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    @(posedge clk);
    #1;
    chk_reset("mid_reset_held");
    rst_n = 1'b1;
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd0, 4'b0000, 0), "post_reset_ready");
    step(4'b0000, 0, 0, 0, e(1, 0, 2'd0, 4'b0000, 0), "post_reset_no_done");

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
